// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the instruction fetch stage: FSM states, reset PC, bubble word.
package fetch_unit_pkg;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

    localparam logic [31:0] FU_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] FU_NOP      = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues imem requests at pc and fills the IF/ID register,
// buffering the returned word while decode is stalled.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = FU_RESET_PC,
    parameter int          DELAY_SLOT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        redirect,
    input  logic        stall,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_id_pc;
    logic [31:0]  r_id_instr;
    logic         r_id_valid;
    logic [31:0]  r_hold;

    logic         w_eff_redirect;
    logic         w_advance;
    logic         w_squash;
    logic [31:0]  w_src;

    // A redirect only counts when the branch in ID is a real instruction.
    assign w_eff_redirect = redirect & r_id_valid;
    assign w_advance      = !stall && ((r_state == S_REQ && imem_ack) || r_state == S_HOLD);
    assign w_squash       = (DELAY_SLOT == 0) && w_eff_redirect;
    assign w_src          = (r_state == S_HOLD) ? r_hold : imem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_id_pc    <= 32'h0;
            r_id_instr <= FU_NOP;
            r_id_valid <= 1'b0;
            r_hold     <= 32'h0;
        end else if (w_advance) begin
            r_state    <= S_REQ;
            r_pc       <= npc;
            r_id_pc    <= r_pc;
            r_id_instr <= w_squash ? FU_NOP : w_src;
            r_id_valid <= !w_squash;
        end else if (r_state == S_REQ && imem_ack) begin
            // Word arrived while ID is held: park it and drop the request.
            r_state    <= S_HOLD;
            r_hold     <= imem_rdata;
        end
    end

    assign imem_req  = (r_state == S_REQ) && !rst;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign id_pc     = r_id_pc;
    assign id_instr  = r_id_instr;
    assign id_valid  = r_id_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit: one instance with a delay slot, one without.
module tb_fetch_unit;

    typedef struct {
        logic        rst;
        logic        ack;
        logic        stall;
        logic        redir;
        logic [31:0] rdata;
        logic [31:0] npc;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_idpc;
        logic [31:0] e_instr;
        logic        e_valid;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // delay-slot instance (a) and squashing instance (b)
    logic        a_rst, a_redir, a_stall, a_ack;
    logic [31:0] a_npc, a_rdata;
    logic        a_req, a_valid;
    logic [31:0] a_addr, a_pc, a_idpc, a_instr;
    logic        b_rst, b_redir, b_stall, b_ack;
    logic [31:0] b_npc, b_rdata;
    logic        b_req, b_valid;
    logic [31:0] b_addr, b_pc, b_idpc, b_instr;

    fetch_unit #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1)) u_a (
        .clk(clk), .rst(a_rst), .npc(a_npc), .redirect(a_redir), .stall(a_stall),
        .imem_ack(a_ack), .imem_rdata(a_rdata), .imem_req(a_req), .imem_addr(a_addr),
        .pc(a_pc), .id_pc(a_idpc), .id_instr(a_instr), .id_valid(a_valid)
    );

    fetch_unit #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(0)) u_b (
        .clk(clk), .rst(b_rst), .npc(b_npc), .redirect(b_redir), .stall(b_stall),
        .imem_ack(b_ack), .imem_rdata(b_rdata), .imem_req(b_req), .imem_addr(b_addr),
        .pc(b_pc), .id_pc(b_idpc), .id_instr(b_instr), .id_valid(b_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] iw(input logic [31:0] a);
        return {16'h8C00, a[15:0]};
    endfunction

    function automatic vec_t mk(input logic rst, input logic ack, input logic stall,
                                input logic redir, input logic [31:0] rdata,
                                input logic [31:0] npc, input logic e_req,
                                input logic [31:0] e_addr, input logic [31:0] e_idpc,
                                input logic [31:0] e_instr, input logic e_valid);
        vec_t v;
        v.rst = rst; v.ack = ack; v.stall = stall; v.redir = redir;
        v.rdata = rdata; v.npc = npc; v.e_req = e_req; v.e_addr = e_addr;
        v.e_idpc = e_idpc; v.e_instr = e_instr; v.e_valid = e_valid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input bit use_b, input vec_t v, input string tag);
        @(negedge clk);
        if (!use_b) begin
            a_rst = v.rst; a_ack = v.ack; a_stall = v.stall; a_redir = v.redir;
            a_rdata = v.rdata; a_npc = v.npc;
        end else begin
            b_rst = v.rst; b_ack = v.ack; b_stall = v.stall; b_redir = v.redir;
            b_rdata = v.rdata; b_npc = v.npc;
        end
        @(posedge clk);
        #1;
        if (!use_b) begin
            chk({tag, ".req"},   {31'b0, a_req},   {31'b0, v.e_req});
            chk({tag, ".addr"},  a_addr,           v.e_addr);
            chk({tag, ".pc"},    a_pc,             v.e_addr);
            chk({tag, ".idpc"},  a_idpc,           v.e_idpc);
            chk({tag, ".instr"}, a_instr,          v.e_instr);
            chk({tag, ".valid"}, {31'b0, a_valid}, {31'b0, v.e_valid});
        end else begin
            chk({tag, ".req"},   {31'b0, b_req},   {31'b0, v.e_req});
            chk({tag, ".addr"},  b_addr,           v.e_addr);
            chk({tag, ".pc"},    b_pc,             v.e_addr);
            chk({tag, ".idpc"},  b_idpc,           v.e_idpc);
            chk({tag, ".instr"}, b_instr,          v.e_instr);
            chk({tag, ".valid"}, {31'b0, b_valid}, {31'b0, v.e_valid});
        end
    endtask

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    vec_t ta[18];
    vec_t tb[6];

    initial begin
        a_rst = 1; a_ack = 0; a_stall = 0; a_redir = 0; a_rdata = 0; a_npc = 0;
        b_rst = 1; b_ack = 0; b_stall = 0; b_redir = 0; b_rdata = 0; b_npc = 0;

        //         rst ack stl red rdata                npc            req addr           idpc           instr                valid
        ta[0]  = mk(1, 0, 0, 0, JUNK,                32'h0,         0, 32'h3000,      32'h0,         32'h0,               0);
        ta[1]  = mk(0, 1, 0, 0, iw(32'h3000),        32'h3004,      1, 32'h3004,      32'h3000,      iw(32'h3000),        1);
        // ack held off for 0x3004, with stall/redirect noise that must be ignored
        ta[2]  = mk(0, 0, 0, 0, JUNK,                32'h3008,      1, 32'h3004,      32'h3000,      iw(32'h3000),        1);
        ta[3]  = mk(0, 0, 1, 1, JUNK,                32'h3040,      1, 32'h3004,      32'h3000,      iw(32'h3000),        1);
        ta[4]  = mk(0, 0, 0, 0, JUNK,                32'h3008,      1, 32'h3004,      32'h3000,      iw(32'h3000),        1);
        ta[5]  = mk(0, 1, 0, 0, iw(32'h3004),        32'h3008,      1, 32'h3008,      32'h3004,      iw(32'h3004),        1);
        // ack for 0x3008 under stall -> HOLD for two cycles, then release from buffer
        ta[6]  = mk(0, 1, 1, 0, iw(32'h3008),        32'h300C,      0, 32'h3008,      32'h3004,      iw(32'h3004),        1);
        ta[7]  = mk(0, 0, 1, 0, JUNK,                32'h300C,      0, 32'h3008,      32'h3004,      iw(32'h3004),        1);
        ta[8]  = mk(0, 0, 0, 0, JUNK,                32'h300C,      1, 32'h300C,      32'h3008,      iw(32'h3008),        1);
        // taken branch at 0x3008: delay slot 0x300C still executes
        ta[9]  = mk(0, 1, 0, 1, iw(32'h300C),        32'h3040,      1, 32'h3040,      32'h300C,      iw(32'h300C),        1);
        ta[10] = mk(0, 1, 0, 0, iw(32'h3040),        32'h3044,      1, 32'h3044,      32'h3040,      iw(32'h3040),        1);
        // enter HOLD, then reset from HOLD
        ta[11] = mk(0, 1, 1, 0, iw(32'h3044),        32'h3048,      0, 32'h3044,      32'h3040,      iw(32'h3040),        1);
        ta[12] = mk(1, 0, 1, 1, JUNK,                32'h3048,      0, 32'h3000,      32'h0,         32'h0,               0);
        ta[13] = mk(0, 0, 0, 0, JUNK,                32'h3004,      1, 32'h3000,      32'h0,         32'h0,               0);
        // reset with a request pending and an ack in the same edge: reset wins
        ta[14] = mk(1, 1, 0, 1, JUNK,                32'h3004,      0, 32'h3000,      32'h0,         32'h0,               0);
        ta[15] = mk(0, 1, 0, 0, iw(32'h3000),        32'h3004,      1, 32'h3004,      32'h3000,      iw(32'h3000),        1);
        // wrap-around supplied by npc
        ta[16] = mk(0, 1, 0, 0, iw(32'h3004),        32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h3004,      iw(32'h3004),        1);
        ta[17] = mk(0, 1, 0, 0, iw(32'hFFFF_FFFC),   32'h0,         1, 32'h0,         32'hFFFF_FFFC, iw(32'hFFFF_FFFC),   1);

        tb[0]  = mk(1, 0, 0, 0, JUNK,                32'h0,         0, 32'h3000,      32'h0,         32'h0,               0);
        tb[1]  = mk(0, 1, 0, 1, iw(32'h3000),        32'h3004,      1, 32'h3004,      32'h3000,      iw(32'h3000),        1);
        tb[2]  = mk(0, 1, 0, 0, iw(32'h3004),        32'h3008,      1, 32'h3008,      32'h3004,      iw(32'h3004),        1);
        tb[3]  = mk(0, 1, 0, 0, iw(32'h3008),        32'h300C,      1, 32'h300C,      32'h3008,      iw(32'h3008),        1);
        // branch at 0x3008 taken: slot squashed
        tb[4]  = mk(0, 1, 0, 1, iw(32'h300C),        32'h3040,      1, 32'h3040,      32'h300C,      32'h0,               0);
        // redirect still high but ID holds a bubble: not effective
        tb[5]  = mk(0, 1, 0, 1, iw(32'h3040),        32'h3044,      1, 32'h3044,      32'h3040,      iw(32'h3040),        1);

        for (int i = 0; i < 18; i++) run_vec(1'b0, ta[i], $sformatf("a%0d", i));
        for (int i = 0; i < 6; i++)  run_vec(1'b1, tb[i], $sformatf("b%0d", i));

        // squash out of HOLD: buffered slot word must also be dropped
        run_vec(1'b1, mk(0, 1, 1, 0, iw(32'h3044), 32'h3048, 0, 32'h3044, 32'h3040, iw(32'h3040), 1), "bh0");
        run_vec(1'b1, mk(0, 0, 0, 1, JUNK,         32'h3080, 1, 32'h3080, 32'h3044, 32'h0,        0), "bh1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
